// File: rtl/pcu_pkg.sv
// Shared definitions for the PC / branch unit: state encoding, branch-select
// encodings, default return-stack depth and the branch-condition helper.
package pcu_pkg;

  // Default number of return-address stack entries.
  localparam int unsigned PCU_RAS_DEPTH = 4;

  // Fetch FSM state encoding.
  typedef logic [0:0] pcu_state_t;
  localparam pcu_state_t FETCH  = 1'b0;
  localparam pcu_state_t BUBBLE = 1'b1;

  // Branch-select encodings.
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_BZ   = 2'b01;
  localparam logic [1:0] BS_BNZ  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  // A branch is taken only when not disabled and its condition holds.
  function automatic logic branch_taken(input logic [1:0] bs, input logic b_d, input logic z);
    logic cond;
    case (bs)
      BS_NONE: cond = 1'b0;
      BS_BZ:   cond = z;
      BS_BNZ:  cond = !z;
      BS_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    return !b_d && cond;
  endfunction

endpackage

// File: rtl/pcu_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty returns EMPTY_ADDR. Either case pulses o_err for one cycle.
module pcu_ras
  import pcu_pkg::*;
#(
  parameter int unsigned DEPTH      = PCU_RAS_DEPTH,
  parameter logic [7:0]  EMPTY_ADDR = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_push_addr,
  output logic [7:0] o_pop_addr,
  output logic       o_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_ptr;    // next slot to write; newest entry sits just below it
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_ptr_dec;
  logic          w_full;
  logic          w_empty;

  // Circular pointer arithmetic and pop data selection.
  always_comb begin
    w_ptr_inc  = (r_ptr == LAST_IDX) ? '0 : r_ptr + PW'(1);
    w_ptr_dec  = (r_ptr == '0) ? LAST_IDX : r_ptr - PW'(1);
    w_full     = (r_count == FULL_CNT);
    w_empty    = (r_count == '0);
    o_pop_addr = w_empty ? EMPTY_ADDR : r_mem[w_ptr_dec];
  end

  // Stack storage; pop wins if both strobes are ever raised together.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_pop) begin
      r_mem[r_ptr] <= i_push_addr;
    end
  end

  // Pointer, occupancy and one-cycle error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_pop) begin
        if (w_empty) begin
          r_err <= 1'b1;
        end else begin
          r_ptr   <= w_ptr_dec;
          r_count <= r_count - CW'(1);
        end
      end else if (i_push) begin
        r_ptr <= w_ptr_inc;
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump/call/return redirect and a one-cycle fetch
// bubble after every redirect. Define PCU_RAS_EN to add the return-address
// stack (pcu_ras) and the RAS_ERR output; otherwise CALL is a plain jump and
// RET is ignored.
module pc_branch_unit
  import pcu_pkg::*;
#(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter int unsigned RAS_DEPTH = PCU_RAS_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STALL,
  input  logic [1:0] BS,
  input  logic       B_D,
  input  logic       Z,
  input  logic [7:0] TGT,
  input  logic       CALL,
  input  logic       RET,
  output logic [7:0] PC,
  output logic       PC_VALID,
  output logic       FLUSH
`ifdef PCU_RAS_EN
  ,
  output logic       RAS_ERR
`endif
);

  pcu_state_t r_state;
  logic [7:0] r_pc;
  logic       r_pc_valid;
  logic       r_flush;

  logic       w_taken;
  logic       w_redirect;
  logic [7:0] w_target;

  assign w_taken = branch_taken(BS, B_D, Z);

`ifdef PCU_RAS_EN
  logic       w_fire;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_ret_addr;
  logic [7:0] w_pop_addr;

  // Stack only moves on a real, unstalled fetch; RET outranks CALL.
  assign w_fire     = (r_state == FETCH) && !STALL;
  assign w_pop      = w_fire && RET;
  assign w_push     = w_fire && CALL && !RET;
  assign w_ret_addr = r_pc + 8'd1;
  assign w_redirect = RET || CALL || w_taken;
  assign w_target   = RET ? w_pop_addr : TGT;

  pcu_ras #(
    .DEPTH      (RAS_DEPTH),
    .EMPTY_ADDR (RESET_PC)
  ) u_ras (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_addr (w_ret_addr),
    .o_pop_addr  (w_pop_addr),
    .o_err       (RAS_ERR)
  );
`else
  // No stack: RET and the depth parameter have no function in this build.
  logic w_unused_ret;
  localparam int unsigned lp_unused_ras_depth = RAS_DEPTH;

  assign w_unused_ret = RET;
  assign w_redirect   = CALL || w_taken;
  assign w_target     = TGT;
`endif

  // Fetch FSM: redirect from FETCH opens a one-cycle bubble; STALL freezes all.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b1;
      r_flush    <= 1'b0;
    end else if (!STALL) begin
      if (r_state == BUBBLE) begin
        r_state    <= FETCH;
        r_pc_valid <= 1'b1;
        r_flush    <= 1'b0;
      end else if (w_redirect) begin
        r_state    <= BUBBLE;
        r_pc       <= w_target;
        r_pc_valid <= 1'b0;
        r_flush    <= 1'b1;
      end else begin
        r_pc       <= r_pc + 8'd1;
        r_pc_valid <= 1'b1;
        r_flush    <= 1'b0;
      end
    end
  end

  assign PC       = r_pc;
  assign PC_VALID = r_pc_valid;
  assign FLUSH    = r_flush;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit. Inputs change on the falling edge and
// outputs are checked on the following falling edge. Return-stack scenarios
// are compiled in only when PCU_RAS_EN is defined.
module tb_pc_branch_unit;
  import pcu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       STALL;
  logic [1:0] BS;
  logic       B_D;
  logic       Z;
  logic [7:0] TGT;
  logic       CALL;
  logic       RET;
  logic [7:0] PC;
  logic       PC_VALID;
  logic       FLUSH;
`ifdef PCU_RAS_EN
  logic       RAS_ERR;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       stall;
    logic [1:0] bs;
    logic       b_d;
    logic       z;
    logic       call;
    logic       ret;
    logic [7:0] tgt;
    logic [7:0] pc;   // expected after the next edge
    logic       v;
    logic       f;
  } step_t;

  pc_branch_unit #(
    .RESET_PC  (8'h00),
    .RAS_DEPTH (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .STALL    (STALL),
    .BS       (BS),
    .B_D      (B_D),
    .Z        (Z),
    .TGT      (TGT),
    .CALL     (CALL),
    .RET      (RET),
    .PC       (PC),
    .PC_VALID (PC_VALID),
    .FLUSH    (FLUSH)
`ifdef PCU_RAS_EN
    ,
    .RAS_ERR  (RAS_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic step_t st(input logic stall, input logic [1:0] bs, input logic b_d,
                               input logic z, input logic call, input logic ret,
                               input logic [7:0] tgt, input logic [7:0] pc, input logic v,
                               input logic f);
    step_t s;
    s.stall = stall; s.bs = bs; s.b_d = b_d; s.z = z; s.call = call; s.ret = ret;
    s.tgt = tgt; s.pc = pc; s.v = v; s.f = f;
    return s;
  endfunction

  function automatic step_t nop(input logic [7:0] pc);
    return st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, pc, 1'b1, 1'b0);
  endfunction

  task automatic apply(input step_t s);
    STALL = s.stall; BS = s.bs; B_D = s.b_d; Z = s.z;
    CALL = s.call; RET = s.ret; TGT = s.tgt;
  endtask

  // Jump to addr from FETCH; returns on a falling edge with PC=addr valid.
  task automatic goto(input logic [7:0] addr);
    apply(st(1'b0, BS_JMP, 1'b0, 1'b0, 1'b0, 1'b0, addr, 8'h00, 1'b0, 1'b0));
    @(negedge CLK);
    apply(nop(8'h00));
    @(negedge CLK);
  endtask

  task automatic pulse_reset;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    apply(nop(8'h00));
  endtask

  task automatic test_reset;
    apply(nop(8'h00));
    RST = 1'b1;
    #2;
    n_vec++;
    if ({PC, PC_VALID, FLUSH} !== {8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: got pc=%h v=%b f=%b want pc=00 v=1 f=0", PC, PC_VALID, FLUSH);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {i[7:0], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_run[%0d]: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, PC, PC_VALID, FLUSH, i[7:0]);
      end
    end
  endtask

  task automatic test_wrap;
    step_t v[$];
    goto(8'hFE);
    v = '{nop(8'hFF), nop(8'h00), nop(8'h01)};
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {v[i].pc, v[i].v, v[i].f}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                 i, PC, PC_VALID, FLUSH, v[i].pc, v[i].v, v[i].f);
      end
    end
  endtask

  // Each case starts at PC=10; taken cases expect the target with a flush.
  task automatic test_branch;
    step_t c[$];
    logic [7:0] p1;
    logic [7:0] p2;
    c = '{
      st(1'b0, BS_BZ,   1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 1'b1),
      st(1'b0, BS_BZ,   1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h11, 1'b1, 1'b0),
      st(1'b0, BS_BNZ,  1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55, 1'b0, 1'b1),
      st(1'b0, BS_BNZ,  1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h11, 1'b1, 1'b0),
      st(1'b0, BS_JMP,  1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 8'h66, 1'b0, 1'b1),
      st(1'b0, BS_JMP,  1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h11, 1'b1, 1'b0),
      st(1'b0, BS_BZ,   1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h11, 1'b1, 1'b0),
      st(1'b0, BS_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h11, 1'b1, 1'b0)
    };
    foreach (c[i]) begin
      goto(8'h10);
      apply(c[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {c[i].pc, c[i].v, c[i].f}) begin
        n_err++;
        $display("FAIL branch[%0d] edge1: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                 i, PC, PC_VALID, FLUSH, c[i].pc, c[i].v, c[i].f);
      end
      p1 = c[i].f ? c[i].pc : 8'h12;
      p2 = c[i].f ? c[i].pc + 8'd1 : 8'h13;
      apply(nop(8'h00));
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {p1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL branch[%0d] edge2: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, PC, PC_VALID, FLUSH, p1);
      end
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {p2, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL branch[%0d] edge3: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, PC, PC_VALID, FLUSH, p2);
      end
    end
  endtask

  task automatic test_stall;
    step_t v[$];
    goto(8'h10);
    v = '{
      st(1'b1, BS_JMP,  1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h10, 1'b1, 1'b0),
      st(1'b1, BS_JMP,  1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h10, 1'b1, 1'b0),
      st(1'b0, BS_JMP,  1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 1'b1),
      st(1'b1, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b1),
      st(1'b1, BS_JMP,  1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 8'h40, 1'b0, 1'b1),
      nop(8'h40),
      st(1'b1, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0),
      nop(8'h41)
    };
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {v[i].pc, v[i].v, v[i].f}) begin
        n_err++;
        $display("FAIL stall[%0d]: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                 i, PC, PC_VALID, FLUSH, v[i].pc, v[i].v, v[i].f);
      end
    end
  endtask

  // Redirect requests raised during the bubble are dropped; the next one works.
  task automatic test_back_to_back;
    step_t v[$];
    goto(8'h30);
    v = '{
      st(1'b0, BS_JMP, 1'b0, 1'b0, 1'b0, 1'b0, 8'h70, 8'h70, 1'b0, 1'b1),
      st(1'b0, BS_JMP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h90, 8'h70, 1'b1, 1'b0),
      st(1'b0, BS_JMP, 1'b0, 1'b0, 1'b0, 1'b0, 8'h90, 8'h90, 1'b0, 1'b1),
      nop(8'h90),
      nop(8'h91)
    };
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {v[i].pc, v[i].v, v[i].f}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                 i, PC, PC_VALID, FLUSH, v[i].pc, v[i].v, v[i].f);
      end
    end
  endtask

  // Reset landing in a bubble or a stall must leave no flush behind.
  task automatic test_reset_abort;
    for (int k = 0; k < 2; k++) begin
      goto(8'h30);
      apply(st(k == 1, BS_JMP, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0));
      @(negedge CLK);
      if (k == 0) apply(nop(8'h00));
      #2;
      RST = 1'b1;
      #1;
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {8'h00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_abort[%0d] async: got pc=%h v=%b f=%b want pc=00 v=1 f=0",
                 k, PC, PC_VALID, FLUSH);
      end
      @(negedge CLK);
      RST = 1'b0;
      apply(nop(8'h00));
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {8'h01, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_abort[%0d] after: got pc=%h v=%b f=%b want pc=01 v=1 f=0",
                 k, PC, PC_VALID, FLUSH);
      end
    end
  endtask

`ifdef PCU_RAS_EN
  task automatic test_ras;
    step_t v[$];
    logic e[$];
    pulse_reset();
    goto(8'h20);
    v = '{
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1),
      nop(8'h80), nop(8'h81),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h21, 1'b0, 1'b1),
      nop(8'h21), nop(8'h22)
    };
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH, RAS_ERR} !== {v[i].pc, v[i].v, v[i].f, e[i]}) begin
        n_err++;
        $display("FAIL ras_call_ret[%0d]: got pc=%h v=%b f=%b err=%b want pc=%h v=%b f=%b err=%b",
                 i, PC, PC_VALID, FLUSH, RAS_ERR, v[i].pc, v[i].v, v[i].f, e[i]);
      end
    end
    // Five nested calls from PC=00 overflow a 4-deep stack, then drain it.
    pulse_reset();
    v = '{
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 1'b0, 1'b1), nop(8'h40),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 8'h41, 1'b0, 1'b1), nop(8'h41),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 8'h42, 1'b0, 1'b1), nop(8'h42),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h43, 8'h43, 1'b0, 1'b1), nop(8'h43),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 8'h44, 1'b0, 1'b1), nop(8'h44),
      nop(8'h45),
      st(1'b0, BS_JMP,  1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 8'h44, 1'b0, 1'b1), nop(8'h44),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h43, 1'b0, 1'b1), nop(8'h43),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h42, 1'b0, 1'b1), nop(8'h42),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h41, 1'b0, 1'b1), nop(8'h41),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1), nop(8'h00)
    };
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH, RAS_ERR} !== {v[i].pc, v[i].v, v[i].f, e[i]}) begin
        n_err++;
        $display("FAIL ras_nest[%0d]: got pc=%h v=%b f=%b err=%b want pc=%h v=%b f=%b err=%b",
                 i, PC, PC_VALID, FLUSH, RAS_ERR, v[i].pc, v[i].v, v[i].f, e[i]);
      end
    end
  endtask
`else
  // Without the stack CALL is a plain jump and RET does nothing.
  task automatic test_call_jump;
    step_t v[$];
    goto(8'h20);
    v = '{
      st(1'b0, BS_BZ,   1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1),
      nop(8'h80),
      st(1'b0, BS_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 1'b0),
      nop(8'h82)
    };
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge CLK);
      n_vec++;
      if ({PC, PC_VALID, FLUSH} !== {v[i].pc, v[i].v, v[i].f}) begin
        n_err++;
        $display("FAIL call_jump[%0d]: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                 i, PC, PC_VALID, FLUSH, v[i].pc, v[i].v, v[i].f);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_stall();
    test_back_to_back();
    test_reset_abort();
`ifdef PCU_RAS_EN
    test_ras();
`else
    test_call_jump();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
